// File: rtl/csr_access.sv
// csr_access: sequences a RISC-V Zicsr instruction as read, optional write, then response
// Ports: i_clk/i_rst clock and sync reset; i_req/o_ready accept handshake with i_funct3,
// i_csr_addr, i_rs1_idx, i_rs1_data, i_zimm operands; i_flush aborts a pending read;
// o_raddr/i_rvalid/i_rdata read side; o_wren/o_waddr/o_wdata write side;
// o_done/o_rd_data/o_illegal completion.
module csr_access #(
  parameter int TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  output logic        o_ready,
  input  logic [2:0]  i_funct3,
  input  logic [11:0] i_csr_addr,
  input  logic [4:0]  i_rs1_idx,
  input  logic [31:0] i_rs1_data,
  input  logic [4:0]  i_zimm,
  input  logic        i_flush,
  output logic [11:0] o_raddr,
  input  logic        i_rvalid,
  input  logic [31:0] i_rdata,
  output logic        o_wren,
  output logic [11:0] o_waddr,
  output logic [31:0] o_wdata,
  output logic        o_done,
  output logic [31:0] o_rd_data,
  output logic        o_illegal
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t      r_state, w_next;
  logic [2:0]  r_funct3;
  logic [11:0] r_addr;
  logic [4:0]  r_rs1_idx, r_zimm;
  logic [31:0] r_rs1_data, r_old;
  logic [7:0]  r_cnt;
  logic        r_illegal;
  logic        w_accept, w_legal_in, w_we, w_timeout;
  logic [31:0] w_src, w_new;
  assign w_accept   = r_state == IDLE && i_req && !i_flush;
  assign w_legal_in = i_funct3[1:0] != 2'b00;
  assign w_src      = r_funct3[2] ? {27'd0, r_zimm} : r_rs1_data;
  // set/clear forms skip the write when their source operand is register x0 or a zero immediate
  assign w_we       = r_funct3[1:0] == 2'b01 || (r_funct3[2] ? r_zimm != 5'd0 : r_rs1_idx != 5'd0);
  assign w_new      = r_funct3[1:0] == 2'b01 ? w_src :
                      r_funct3[1:0] == 2'b10 ? (r_old | w_src) : (r_old & ~w_src);
  assign w_timeout  = r_cnt == 8'(TIMEOUT - 1);
  always_comb begin
    w_next = IDLE;
    // flush outranks a same-cycle rvalid while reading
    w_next = r_state == IDLE  ? (w_accept ? (w_legal_in ? READ : RESP) : IDLE) :
             r_state == READ  ? (i_flush ? IDLE : i_rvalid ? (w_we ? WRITE : RESP) : w_timeout ? RESP : READ) :
             r_state == WRITE ? RESP : IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_funct3   <= '0;
      r_addr     <= '0;
      r_rs1_idx  <= '0;
      r_rs1_data <= '0;
      r_zimm     <= '0;
      r_old      <= '0;
      r_cnt      <= '0;
      r_illegal  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_funct3   <= i_funct3;
        r_addr     <= i_csr_addr;
        r_rs1_idx  <= i_rs1_idx;
        r_rs1_data <= i_rs1_data;
        r_zimm     <= i_zimm;
        r_old      <= '0;
        r_cnt      <= '0;
        r_illegal  <= !w_legal_in;
      end
      if (r_state == READ) begin
        r_cnt <= r_cnt + 8'd1;
        if (!i_flush && i_rvalid) r_old <= i_rdata;
        else if (!i_flush && w_timeout) r_illegal <= 1'b1;
      end
    end
  end
  assign o_ready   = r_state == IDLE;
  assign o_raddr   = r_addr;
  assign o_wren    = r_state == WRITE;
  assign o_waddr   = r_addr;
  assign o_wdata   = o_wren ? w_new : 32'd0;
  assign o_done    = r_state == RESP;
  assign o_illegal = o_done && r_illegal;
  assign o_rd_data = o_done && !r_illegal ? r_old : 32'd0;
endmodule

// File: tb/tb_csr_access.sv
// tb_csr_access: directed and randomized transactions checked against a cycle-count reference model
module tb_csr_access;
  localparam int TO = 4;
  logic        clk = 1'b0, rst, req, flush, rvalid, ready, wren, done, illegal;
  logic [2:0]  f3;
  logic [11:0] addr, raddr, waddr;
  logic [4:0]  idx, zimm;
  logic [31:0] rs1, rdata, wdata, rd_data;
  int checks = 0, failures = 0, cyc = 0;
  csr_access #(.TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .o_ready(ready), .i_funct3(f3),
    .i_csr_addr(addr), .i_rs1_idx(idx), .i_rs1_data(rs1), .i_zimm(zimm),
    .i_flush(flush), .o_raddr(raddr), .i_rvalid(rvalid), .i_rdata(rdata),
    .o_wren(wren), .o_waddr(waddr), .o_wdata(wdata), .o_done(done),
    .o_rd_data(rd_data), .o_illegal(illegal)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_flags"}, {ready, wren, done, illegal}, 4'b1000);
    chk({tag, "_raddr"}, raddr, 0);
    chk({tag, "_waddr"}, waddr, 0);
    chk({tag, "_wdata"}, wdata, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
  endtask
  function automatic bit ref_we(input logic [2:0] f, input logic [4:0] i, input logic [4:0] z);
    if (f == 3'd1 || f == 3'd5) return 1'b1;
    if (f == 3'd2 || f == 3'd3) return i != 0;
    return z != 0;
  endfunction
  function automatic logic [31:0] ref_new(input logic [2:0] f, input logic [31:0] old,
                                          input logic [31:0] r, input logic [4:0] z);
    logic [31:0] src;
    src = (f >= 3'd5) ? 32'(z) : r;
    if (f == 3'd1 || f == 3'd5) return src;
    if (f == 3'd2 || f == 3'd6) return old | src;
    return old & ~src;
  endfunction
  task automatic run_txn(input logic [2:0] f, input logic [11:0] a, input logic [4:0] i,
                         input logic [31:0] d, input logic [4:0] z, input logic [31:0] rd,
                         input int delay, input int fl_at, input bit flate);
    int t0;
    bit legal, we, to;
    logic [31:0] old;
    legal = f != 3'd0 && f != 3'd4;
    old = 0;
    to = 0;
    f3 = f; addr = a; idx = i; rs1 = d; zimm = z; req = 1'b1; flush = 1'b0; rvalid = 1'b0;
    chk("accept_ready", ready, 1);
    t0 = cyc;
    step;
    req = 1'b0;
    f3 = 3'($urandom); addr = 12'($urandom); idx = 5'($urandom); rs1 = $urandom; zimm = 5'($urandom);
    if (!legal) begin
      chk("illegal_flags", {done, illegal, wren}, 3'b110);
      chk("illegal_rd_data", rd_data, 0);
      chk("illegal_raddr", raddr, a);
      chk("illegal_latency", cyc - t0, 1);
      step;
      chk("illegal_back_idle", {ready, done}, 2'b10);
      return;
    end
    for (int k = 0; k < TO; k++) begin
      rvalid = k == delay;
      rdata = (k == delay) ? rd : $urandom;
      flush = k == fl_at;
      chk("read_busy", {ready, wren, done}, 3'b000);
      chk("read_raddr", raddr, a);
      if (flush) begin
        step;
        flush = 1'b0;
        rvalid = 1'b0;
        chk("flush_idle", {ready, wren, done}, 3'b100);
        return;
      end
      if (rvalid) begin
        old = rd;
        step;
        break;
      end
      if (k == TO - 1) begin
        to = 1;
        step;
        break;
      end
      step;
    end
    rvalid = 1'b0;
    rdata = $urandom;
    flush = flate;
    we = !to && ref_we(f, i, z);
    if (we) begin
      chk("write_flags", {wren, done}, 2'b10);
      chk("write_waddr", waddr, a);
      chk("write_wdata", wdata, ref_new(f, old, d, z));
      step;
    end
    chk("resp_flags", {done, illegal, wren}, {1'b1, to, 1'b0});
    chk("resp_rd_data", rd_data, to ? 32'd0 : old);
    chk("resp_latency", cyc - t0, to ? TO + 1 : delay + 2 + int'(we));
    step;
    flush = 1'b0;
    chk("resp_back_idle", {ready, done, wren}, 3'b100);
  endtask
  initial begin
    rst = 1'b1; req = 1'b0; flush = 1'b0; rvalid = 1'b0; f3 = 3'd1; addr = 12'hABC;
    idx = 5'd1; rs1 = 32'h1234; zimm = 5'd3; rdata = 32'h5678;
    step;
    step;
    chk_reset("reset");
    rst = 1'b0;
    run_txn(3'd1, 12'h300, 5'd5, 32'hDEADBEEF, 5'd0, 32'h11, 0, 99, 1'b0);
    run_txn(3'd2, 12'h123, 5'd0, 32'hFFFF0000, 5'd9, 32'h80, 0, 99, 1'b0);
    run_txn(3'd7, 12'h340, 5'd3, 32'h0, 5'h05, 32'hFF, 0, 99, 1'b0);
    run_txn(3'd3, 12'h341, 5'd7, 32'h1, 5'd0, 32'h0, 99, 99, 1'b0);
    run_txn(3'd4, 12'h7AB, 5'd2, 32'h3, 5'd1, 32'h9, 0, 99, 1'b0);
    run_txn(3'd0, 12'h001, 5'd2, 32'h3, 5'd1, 32'h9, 0, 99, 1'b0);
    run_txn(3'd1, 12'h305, 5'd1, 32'h55, 5'd0, 32'h66, 3, 1, 1'b0);
    run_txn(3'd1, 12'h305, 5'd1, 32'h55, 5'd0, 32'h66, 0, 99, 1'b0);
    run_txn(3'd6, 12'h306, 5'd0, 32'h0, 5'h1F, 32'hAA00, 1, 99, 1'b1);
    run_txn(3'd2, 12'h307, 5'd4, 32'h0F0F, 5'd0, 32'hF000, 2, 2, 1'b0);
    req = 1'b1; flush = 1'b1; f3 = 3'd1; addr = 12'h222;
    step;
    chk("idle_flush_blocks", {ready, done, wren}, 3'b100);
    req = 1'b0; flush = 1'b0;
    req = 1'b1; f3 = 3'd1; addr = 12'h3FF; idx = 5'd1; rs1 = 32'hCAFE;
    step;
    req = 1'b0; rvalid = 1'b0;
    chk("rst_mid_read", ready, 0);
    step;
    rst = 1'b1;
    step;
    chk_reset("rst_mid");
    rst = 1'b0;
    rvalid = 1'b1; rdata = 32'h77;
    for (int c = 0; c < 4; c++) begin
      chk("post_rst_quiet", {ready, wren, done}, 3'b100);
      step;
    end
    rvalid = 1'b0;
    for (int n = 0; n < 60; n++) begin
      logic [4:0] ri, rz;
      ri = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      rz = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      run_txn(3'($urandom_range(0, 7)), 12'($urandom), ri, $urandom, rz, $urandom,
              $urandom_range(0, 5), $urandom_range(0, 12), 1'($urandom_range(0, 1)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
